// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared widths, depth, dump FSM encoding and address slice bounds
package dmem_pkg;

  localparam int DEF_DATA_W = 64;
  localparam int DEF_ADDR_W = 9;
  localparam int DEPTH      = 512;

  // Word index is memAddr[IDX_MSB:IDX_LSB] on the cpu's big-endian address bus
  localparam int IDX_MSB = 23;
  localparam int IDX_LSB = 31;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    ACK  = 2'd2,
    DONE = 2'd3
  } dump_state_t;

endpackage

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - single-port storage with one shared read/write port and registered read data
module dmem_array #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [0:DATA_W-1] wdata,
  output logic [0:DATA_W-1] q
);

  logic [0:DATA_W-1] mem [0:(1<<ADDR_W)-1];

  // Contents survive reset; q is only meaningful the cycle after a read
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wdata;
      end else begin
        q <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/dmem_resp.sv
// rtl/dmem_resp.sv - cpu data-memory responder with a background dump engine on a valid/ready stream
module dmem_resp
  import dmem_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              memEn,
  input  logic              memWrEn,
  input  logic [0:31]       memAddr,
  input  logic [0:DATA_W-1] wrData,
  output logic [0:DATA_W-1] rdData,
  input  logic              dump_start,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [0:ADDR_W-1] dump_addr,
  output logic [0:DATA_W-1] dump_data,
  output logic              dump_done,
  output logic              busy
);

  dump_state_t       state, state_next;
  logic [ADDR_W-1:0] cnt;
  logic [ADDR_W-1:0] cpu_idx;
  logic              dump_rd;
  logic              arr_en;
  logic              arr_we;
  logic [ADDR_W-1:0] arr_addr;
  logic [0:DATA_W-1] arr_q;
  logic              cpu_rd_d;
  logic              dump_rd_d;
  logic [0:DATA_W-1] rd_hold;
  logic [0:DATA_W-1] dump_hold;
  logic              addr_hi_unused;

  assign cpu_idx        = memAddr[IDX_MSB:IDX_LSB];
  assign addr_hi_unused = ^memAddr[0:IDX_MSB-1];

  // The cpu owns the port whenever memEn is high; the dump only reads in idle cycles
  assign dump_rd  = (state == RD) && !memEn;
  assign arr_en   = memEn || dump_rd;
  assign arr_we   = memEn && memWrEn;
  assign arr_addr = memEn ? cpu_idx : cnt;

  dmem_array #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_array (
    .clk  (clk),
    .en   (arr_en),
    .we   (arr_we),
    .addr (arr_addr),
    .wdata(wrData),
    .q    (arr_q)
  );

  // The array output is shared, so each consumer keeps its own copy once q moves on
  assign rdData    = cpu_rd_d ? arr_q : rd_hold;
  assign dump_data = dump_rd_d ? arr_q : dump_hold;

  always_ff @(posedge clk) begin
    if (!reset) begin
      cpu_rd_d  <= 1'b0;
      dump_rd_d <= 1'b0;
      rd_hold   <= '0;
      dump_hold <= '0;
    end else begin
      cpu_rd_d  <= memEn && !memWrEn;
      dump_rd_d <= dump_rd;
      rd_hold   <= rdData;
      dump_hold <= dump_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE && dump_start) begin
        cnt <= '0;
      end else if (state == ACK && dump_ready && !(&cnt)) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (dump_start) state_next = RD;
      RD:   if (!memEn) state_next = ACK;
      ACK:  if (dump_ready) state_next = (&cnt) ? DONE : RD;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign dump_valid = (state == ACK);
  assign dump_done  = (state == DONE);
  assign busy       = (state != IDLE);
  assign dump_addr  = cnt;

endmodule

// File: tb/tb_dmem_resp.sv
// tb/tb_dmem_resp.sv - directed self-checking bench for dmem_resp
module tb_dmem_resp;

  logic        clk = 1'b0;
  logic        reset;
  logic        memEn;
  logic        memWrEn;
  logic [0:31] memAddr;
  logic [0:63] wrData;
  logic [0:63] rdData;
  logic        dump_start;
  logic        dump_valid;
  logic        dump_ready;
  logic [0:8]  dump_addr;
  logic [0:63] dump_data;
  logic        dump_done;
  logic        busy;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  dmem_resp dut (
    .clk       (clk),
    .reset     (reset),
    .memEn     (memEn),
    .memWrEn   (memWrEn),
    .memAddr   (memAddr),
    .wrData    (wrData),
    .rdData    (rdData),
    .dump_start(dump_start),
    .dump_valid(dump_valid),
    .dump_ready(dump_ready),
    .dump_addr (dump_addr),
    .dump_data (dump_data),
    .dump_done (dump_done),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle just after it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n_entries;
    int n_done;
    int done_at;
    int waited;
    logic found;
    logic [0:31] a;

    reset = 1'b0; memEn = 1'b0; memWrEn = 1'b0; memAddr = '0; wrData = '0;
    dump_start = 1'b1; dump_ready = 1'b0;

    repeat (3) step();
    check("reset_rdData", rdData, 64'h0);
    check("reset_dump_valid", dump_valid, 1'b0);
    check("reset_busy", busy, 1'b0);
    check("reset_dump_done", dump_done, 1'b0);
    check("reset_dump_addr", dump_addr, 9'h0);
    check("reset_dump_data", dump_data, 64'h0);

    reset = 1'b1; dump_start = 1'b0;
    n_done = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (dump_done || busy) n_done++;
    end
    check("post_reset_quiet", n_done, 0);

    memEn = 1'b1; memWrEn = 1'b1; memAddr = 32'h0000_0005; wrData = 64'hDEADBEEF_01234567;
    step();
    check("write_keeps_rdData", rdData, 64'h0);
    memWrEn = 1'b0;
    step();
    check("read_after_write", rdData, 64'hDEADBEEF_01234567);
    memEn = 1'b0;
    step();
    check("rdData_holds", rdData, 64'hDEADBEEF_01234567);

    memEn = 1'b1; memWrEn = 1'b1; memAddr = 32'h0000_0203; wrData = 64'h1;
    step();
    memWrEn = 1'b0; memAddr = 32'h0000_0003;
    step();
    check("alias_read", rdData, 64'h1);

    memWrEn = 1'b1;
    for (int i = 0; i < 512; i++) begin
      memAddr = i; wrData = i;
      step();
    end
    memEn = 1'b0; memWrEn = 1'b0;

    dump_ready = 1'b1; dump_start = 1'b1;
    step();
    dump_start = 1'b0;
    check("dump_busy_rises", busy, 1'b1);
    n_entries = 0; n_done = 0; done_at = -1;
    for (int c = 1; c <= 1200; c++) begin
      step();
      if (dump_valid) begin
        check("full_dump_addr", dump_addr, n_entries);
        check("full_dump_data", dump_data, n_entries);
        n_entries++;
      end
      if (dump_done) begin
        n_done++;
        done_at = c;
      end
      if (!busy) break;
    end
    check("full_dump_entries", n_entries, 512);
    check("full_dump_done_count", n_done, 1);
    check("full_dump_done_cycle", done_at, 1024);
    check("full_dump_busy_falls", busy, 1'b0);

    dump_start = 1'b1;
    step();
    dump_start = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 100 && !found; c++) begin
      step();
      if (dump_valid && dump_addr == 9'd7) found = 1'b1;
    end
    check("reach_entry_7", found, 1'b1);
    dump_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      check("bp_valid", dump_valid, 1'b1);
      check("bp_addr", dump_addr, 9'd7);
      check("bp_data", dump_data, 64'd7);
    end
    dump_ready = 1'b1;
    step();
    check("bp_released", dump_valid, 1'b0);

    memEn = 1'b1; memWrEn = 1'b0;
    for (int j = 0; j < 20; j++) begin
      a = 32'hABC0_0000 | (j * 23 + 40);
      memAddr = a;
      step();
      check("contend_rdData", rdData, (j * 23 + 40) % 512);
      check("contend_no_entry", dump_valid, 1'b0);
      check("contend_busy", busy, 1'b1);
    end
    memEn = 1'b0;
    step();
    check("resume_valid", dump_valid, 1'b1);
    check("resume_addr", dump_addr, 9'd8);
    check("resume_data", dump_data, 64'd8);
    check("resume_rdData_holds", rdData, (19 * 23 + 40) % 512);

    found = 1'b0;
    waited = 0;
    while (!found && waited < 400) begin
      step();
      waited++;
      if (dump_valid && dump_addr == 9'd100) found = 1'b1;
    end
    check("reach_entry_100", found, 1'b1);
    reset = 1'b0;
    step();
    reset = 1'b1;
    check("abort_busy", busy, 1'b0);
    check("abort_valid", dump_valid, 1'b0);
    check("abort_done", dump_done, 1'b0);
    check("abort_addr", dump_addr, 9'd0);
    step();
    check("abort_stays_idle", busy, 1'b0);

    dump_start = 1'b1;
    step();
    dump_start = 1'b0;
    check("restart_busy", busy, 1'b1);
    step();
    check("restart_valid", dump_valid, 1'b1);
    check("restart_addr", dump_addr, 9'd0);
    check("restart_data", dump_data, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_resp.md
Name: dmem_resp

Overview:
- Responder end of the CPU data-memory port: serves memEn/memWrEn/memAddr/dataOut requests from the cpu against a 512 x 64-bit single-port storage array.
- Adds a post-run dump engine that streams every location out over a valid/ready channel. This replaces hierarchical memory peeking for the dump and for gate-level runs.
- Sits beside the cpu instance at the top level, in place of the behavioural data memory.

Parameters:
- DATA_W, 64, data word width in bits.
- ADDR_W, 9, word-address width; storage depth is 2**ADDR_W (512).

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-low reset (asserted when 0).
- memEn  in  1  CPU memory access enable.
- memWrEn  in  1  CPU write enable; qualified by memEn.
- memAddr  in  [0:31]  CPU byte/word address; only memAddr[23:31] is used, as the word index.
- wrData  in  [0:DATA_W-1]  CPU store data (the cpu's dataOut).
- rdData  out  [0:DATA_W-1]  load data to the CPU (the cpu's dataIn).
- dump_start  in  1  single-cycle request to start a full dump.
- dump_valid  out  1  dump_addr/dump_data hold a valid entry.
- dump_ready  in  1  sink accepts the entry when dump_valid&dump_ready.
- dump_addr  out  [0:ADDR_W-1]  index of the entry being presented.
- dump_data  out  [0:DATA_W-1]  contents of that entry.
- dump_done  out  1  one-cycle pulse after the last entry is accepted.
- busy  out  1  dump engine not IDLE.

Behaviour:
- Reset (reset==0 at a rising edge):
  - rdData, dump_data, dump_addr, dump_valid, dump_done and busy all go to 0.
  - FSM goes to IDLE and the dump address counter goes to 0.
  - Storage contents are NOT cleared.
- CPU write: memEn=1, memWrEn=1 at edge N writes wrData to mem[memAddr[23:31]] at edge N. rdData is unchanged.
- CPU read: memEn=1, memWrEn=0 at edge N sets rdData = mem[idx] after edge N (1-cycle latency). rdData holds until the next CPU read.
- memEn=0: no storage access by the CPU.
- Port priority: the CPU port always wins. The dump engine may read the array only in a cycle where memEn=0. The CPU never stalls.
- The upper address bits memAddr[0:22] are ignored, so accesses alias modulo 512.
- FSM states:
  - IDLE:
    - dump_start=1 -> RD, with the counter at 0 and busy=1.
    - dump_start is ignored in every other state.
  - RD:
    - If memEn=0: capture mem[counter] into dump_data, set dump_addr=counter and dump_valid=1, go to ACK.
    - If memEn=1: stay in RD, with dump_valid remaining 0.
  - ACK:
    - dump_valid is held high and dump_addr/dump_data are held stable until dump_valid&dump_ready.
    - On the handshake: dump_valid=0.
    - If counter==511 -> DONE; otherwise increment the counter and go to RD.
  - DONE: dump_done=1 for exactly one cycle, then IDLE with busy=0.
- Minimum throughput is one entry per 2 cycles, so a full dump with memEn idle and dump_ready tied high takes 1024 cycles plus DONE.
- A CPU write to an address not yet dumped is visible in the dump. Data already captured in dump_data is not updated.
- Reset mid-dump aborts immediately: IDLE, dump_done is not pulsed, and partial output is discarded.
- dump_start arriving on the same edge as an active reset is ignored.

Decomposition:
- Shared package dmem_pkg:
  - DATA_W and ADDR_W defaults.
  - DEPTH = 512.
  - The FSM state encoding (IDLE=2'd0, RD=2'd1, ACK=2'd2, DONE=2'd3).
  - The memAddr index slice bounds (23, 31).
- One natural sub-module, dmem_array: a single-port 512x64 storage array with a registered read port and a write port, with the arbitration mux kept in dmem_resp.
- The FSM and the counter live in dmem_resp.

Test Plan:
- Reset check: hold reset=0 for 3 cycles with dump_start=1 -> rdData=0, dump_valid=0, busy=0 and dump_done never pulses after release.
- Write then read: write 64'hDEADBEEF_01234567 to memAddr=32'h0000_0005, then read memAddr=32'h0000_0005 on the next cycle -> rdData=64'hDEADBEEF_01234567 one cycle after the read edge.
- Aliasing: write 64'h1 at memAddr=32'h0000_0203, then read 32'h0000_0003 -> rdData=64'h1.
- Full dump: preload mem[i]=i, memEn=0, dump_ready=1, pulse dump_start -> 512 handshakes with dump_addr 0..511 and dump_data==i, then dump_done pulses once in cycle 1025 and busy falls.
- Backpressure and contention:
  - During a dump, hold dump_ready=0 for 10 cycles at dump_addr=7 -> dump_data and dump_addr stay stable and dump_valid stays 1.
  - Assert memEn=1 continuously for 20 cycles while in RD -> no new entry appears and CPU reads return correct data.
- Reset mid-dump: pulse reset=0 at entry 100 -> next cycle busy=0 and dump_valid=0. A fresh dump_start then restarts at dump_addr=0.
